// File: rtl/reward_item_controller.sv
// Reward-item controller: pickup arbitration, one active item,
// per-second timing and expiry pulse for the HUD and tank logic.
module reward_item_controller #(
  parameter int CLK_FREQ  = 100000000,
  parameter int ITEM_TIME = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_reward,
  input  logic       game_pause,
  input  logic [3:0] pickup_req,
  output logic [3:0] pickup_grant,
  output logic       item_laser,
  output logic       item_faster,
  output logic       item_frozen,
  output logic       item_invincible,
  output logic [9:0] item_cnt,
  output logic       item_active,
  output logic       item_expire
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_FREQ - 1);
  localparam logic [9:0]    CMAX = 10'(ITEM_TIME - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  grant_q, grant_d;
  logic        expire_q, expire_d;
  logic [3:0]  win;
  logic        accept;
  logic        tick;

  // Highest set request bit wins; losers are dropped.
  always_comb begin
    win = 4'b0000;
    priority case (1'b1)
      pickup_req[3]: win = 4'b1000;
      pickup_req[2]: win = 4'b0100;
      pickup_req[1]: win = 4'b0010;
      pickup_req[0]: win = 4'b0001;
      default:       win = 4'b0000;
    endcase
  end

  assign accept = enable_reward && (pickup_req != 4'b0000);
  assign tick   = (presc_q == PMAX);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    grant_d  = 4'b0000;
    expire_d = 1'b0;
    if (!enable_reward) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d   = '0;
      flags_d = 4'b0000;
    end else if (accept) begin
      // A pickup beats a coincident expiring tick.
      state_d = ACTIVE;
      presc_d = '0;
      cnt_d   = '0;
      flags_d = win;
      grant_d = win;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          cnt_d   = '0;
        end
        ACTIVE: begin
          if (!game_pause) begin
            if (tick) begin
              presc_d = '0;
              if (cnt_q == CMAX) begin
                state_d  = IDLE;
                cnt_d    = '0;
                flags_d  = 4'b0000;
                expire_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 10'd1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      flags_q  <= 4'b0000;
      grant_q  <= 4'b0000;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
      grant_q  <= grant_d;
      expire_q <= expire_d;
    end
  end

  assign item_laser      = flags_q[3];
  assign item_faster     = flags_q[2];
  assign item_frozen     = flags_q[1];
  assign item_invincible = flags_q[0];
  assign item_active     = |flags_q;
  assign item_cnt        = cnt_q;
  assign pickup_grant    = grant_q;
  assign item_expire     = expire_q;

endmodule

// File: tb/tb_reward_item_controller.sv
// Directed bench for reward_item_controller with CLK_FREQ=10,
// ITEM_TIME=30; each scenario checks a packed output snapshot.
module tb_reward_item_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_reward = 1'b1;
  logic       game_pause = 1'b0;
  logic [3:0] pickup_req = 4'b0000;
  logic [3:0] pickup_grant;
  logic       item_laser, item_faster, item_frozen, item_invincible;
  logic [9:0] item_cnt;
  logic       item_active, item_expire;

  int checks = 0;
  int errors = 0;
  logic [19:0] e;

  reward_item_controller #(.CLK_FREQ(10), .ITEM_TIME(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .enable_reward(enable_reward), .game_pause(game_pause),
    .pickup_req(pickup_req), .pickup_grant(pickup_grant),
    .item_laser(item_laser), .item_faster(item_faster),
    .item_frozen(item_frozen), .item_invincible(item_invincible),
    .item_cnt(item_cnt), .item_active(item_active),
    .item_expire(item_expire)
  );

  always #5 clk = ~clk;

  // {flags[3:0], grant[3:0], cnt[9:0], expire, active}
  function automatic logic [19:0] obs();
    return {item_laser, item_faster, item_frozen, item_invincible,
            pickup_grant, item_cnt, item_expire, item_active};
  endfunction

  function automatic logic [19:0] ex(input logic [3:0] f,
                                     input logic [3:0] g,
                                     input int c, input logic x);
    logic act;
    act = (f != 4'b0000);
    return {f, g, 10'(c), x, act};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pick(input logic [3:0] r);
    pickup_req = r;
    step(1);
    pickup_req = 4'b0000;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    e = ex(4'b0000, 4'b0000, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs(), e);
    end
    step(2);
    rst_n = 1'b1;
    step(2);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL post_reset got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_single_pickup();
    pick(4'b1000);
    checks++;
    e = ex(4'b1000, 4'b1000, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL single_pick got %h exp %h", obs(), e);
    end
    step(1);
    checks++;
    e = ex(4'b1000, 4'b0000, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL grant_one_cycle got %h exp %h", obs(), e);
    end
    step(9);
    checks++;
    e = ex(4'b1000, 4'b0000, 1, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL cnt_1 got %h exp %h", obs(), e);
    end
    step(280);
    checks++;
    e = ex(4'b1000, 4'b0000, 29, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL cnt_29 got %h exp %h", obs(), e);
    end
    step(10);
    checks++;
    e = ex(4'b0000, 4'b0000, 0, 1'b1);
    if (obs() !== e) begin
      errors++;
      $display("FAIL expire got %h exp %h", obs(), e);
    end
    step(1);
    checks++;
    e = ex(4'b0000, 4'b0000, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL expire_one_cycle got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_arbitration();
    pick(4'b0111);
    checks++;
    e = ex(4'b0100, 4'b0100, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL arb_0111 got %h exp %h", obs(), e);
    end
    pick(4'b0011);
    checks++;
    e = ex(4'b0010, 4'b0010, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL arb_0011 got %h exp %h", obs(), e);
    end
    pick(4'b1111);
    checks++;
    e = ex(4'b1000, 4'b1000, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL arb_1111 got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_replace();
    pick(4'b0001);
    step(120);
    checks++;
    e = ex(4'b0001, 4'b0000, 12, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL repl_pre got %h exp %h", obs(), e);
    end
    pick(4'b0010);
    checks++;
    e = ex(4'b0010, 4'b0010, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL repl_new got %h exp %h", obs(), e);
    end
    step(299);
    checks++;
    e = ex(4'b0010, 4'b0000, 29, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL repl_299 got %h exp %h", obs(), e);
    end
    step(1);
    checks++;
    e = ex(4'b0000, 4'b0000, 0, 1'b1);
    if (obs() !== e) begin
      errors++;
      $display("FAIL repl_expire got %h exp %h", obs(), e);
    end
    step(1);
  endtask

  task automatic test_collision();
    pick(4'b0100);
    step(299);
    pick(4'b0001);
    checks++;
    e = ex(4'b0001, 4'b0001, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL collision got %h exp %h", obs(), e);
    end
    step(10);
    checks++;
    e = ex(4'b0001, 4'b0000, 1, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL collision_timer got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_pause();
    pick(4'b1000);
    step(50);
    game_pause = 1'b1;
    step(50);
    checks++;
    e = ex(4'b1000, 4'b0000, 5, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_hold got %h exp %h", obs(), e);
    end
    game_pause = 1'b0;
    step(9);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_shift5 got %h exp %h", obs(), e);
    end
    step(1);
    checks++;
    e = ex(4'b1000, 4'b0000, 6, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_shift6 got %h exp %h", obs(), e);
    end
    step(239);
    checks++;
    e = ex(4'b1000, 4'b0000, 29, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_pre_exp got %h exp %h", obs(), e);
    end
    step(1);
    checks++;
    e = ex(4'b0000, 4'b0000, 0, 1'b1);
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_expire got %h exp %h", obs(), e);
    end
    step(1);
  endtask

  task automatic test_pause_pickup();
    pick(4'b0010);
    step(70);
    game_pause = 1'b1;
    step(5);
    pick(4'b0100);
    checks++;
    e = ex(4'b0100, 4'b0100, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_pick got %h exp %h", obs(), e);
    end
    game_pause = 1'b0;
    step(10);
    checks++;
    e = ex(4'b0100, 4'b0000, 1, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_pick_run got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_enable();
    pick(4'b0100);
    step(25);
    enable_reward = 1'b0;
    step(1);
    checks++;
    e = ex(4'b0000, 4'b0000, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL enable_clear got %h exp %h", obs(), e);
    end
    pick(4'b1000);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL enable_ignore got %h exp %h", obs(), e);
    end
    step(300);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL enable_noexp got %h exp %h", obs(), e);
    end
    enable_reward = 1'b1;
    step(1);
  endtask

  task automatic test_async_reset();
    pick(4'b0010);
    step(55);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    e = ex(4'b0000, 4'b0000, 0, 1'b0);
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_rst got %h exp %h", obs(), e);
    end
    step(3);
    rst_n = 1'b1;
    step(300);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rst_noexp got %h exp %h", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_single_pickup();
    test_arbitration();
    test_replace();
    test_collision();
    test_pause();
    test_pause_pickup();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reward_item_controller.md
Name: reward_item_controller

Overview:
- Owns the reward-item state consumed by the HUD reward-timer display and the tank/enemy logic.
- Accepts item pickup requests, arbitrates simultaneous pickups, and holds exactly one active reward item.
- Times the active item for ITEM_TIME seconds using a prescaled 1 Hz tick.
- Drives the one-hot item flags, the elapsed-seconds count item_cnt (display bar length = 30 - item_cnt), and an expiry pulse.

Parameters:
- CLK_FREQ, 100000000, clk cycles per one-second tick; the bench overrides it to a small value.
- ITEM_TIME, 30, item duration in seconds; must be at least 1 and at most 1023.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- enable_reward  in  1  reward feature enable; low forces a synchronous clear.
- game_pause  in  1  freezes the prescaler and item_cnt; flags are held.
- pickup_req  in  4  one-hot-ish pickup strobe, one cycle wide: bit3 laser, bit2 faster, bit1 frozen, bit0 invincible.
- pickup_grant  out  4  one-hot, registered; the bit of the accepted request, high for one cycle.
- item_laser  out  1  laser item active.
- item_faster  out  1  faster item active.
- item_frozen  out  1  frozen item active.
- item_invincible  out  1  invincible item active.
- item_cnt  out  10  whole seconds elapsed for the active item, range 0..ITEM_TIME-1.
- item_active  out  1  OR of the four item flags.
- item_expire  out  1  one-cycle pulse when the active item times out.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All flags, item_cnt, pickup_grant, item_expire and the prescaler are 0.
- States:
  - IDLE: no item active.
  - ACTIVE: one item active.
- Prescaler: counts 0..CLK_FREQ-1 while in ACTIVE and game_pause is low.
  - tick = (prescaler == CLK_FREQ-1); the prescaler wraps to 0 on tick.
- Arbitration: when enable_reward is high and pickup_req != 0, the highest set bit wins (laser > faster > frozen > invincible). Losing requests are dropped, not queued.
- Accepting a pickup (from IDLE or ACTIVE), at the next edge:
  - state becomes ACTIVE;
  - only the winning flag is set and the others are cleared (a new item replaces the current one);
  - item_cnt and the prescaler are cleared to 0;
  - pickup_grant shows the winning bit for one cycle.
  - Re-picking the same item restarts its timer.
- Timing in ACTIVE:
  - on tick with item_cnt < ITEM_TIME-1, item_cnt increments;
  - on tick with item_cnt == ITEM_TIME-1: flags clear, item_cnt becomes 0, state returns to IDLE, and item_expire is 1 for exactly one cycle.
- Simultaneous pickup and expiring tick: the pickup wins. The new item starts with item_cnt 0 and item_expire stays 0.
- game_pause high: prescaler and item_cnt hold and no tick occurs. Pickups are still accepted and restart the timer.
- enable_reward low: synchronous clear to the reset values, pickup_req is ignored, and item_expire is not pulsed.
- Latency: all outputs are registered.
  - pickup_req to flag/grant: 1 cycle.
  - item_active changes in the same cycle as the flags.
- Invariants:
  - item_active == |flags, and at most one flag is high.
  - item_cnt == 0 whenever the state is IDLE.
  - item_cnt never reaches ITEM_TIME.
- Width: item_cnt is 10 bits. The prescaler is sized with $clog2(CLK_FREQ) bits, minimum 1.
- Reset asserted mid-item: all outputs go to 0 immediately, with no expire pulse.

Test Plan (CLK_FREQ=10, ITEM_TIME=30):
- Single pickup: pickup_req=4'b1000 for 1 cycle → next cycle item_laser=1, pickup_grant=4'b1000 for 1 cycle, item_cnt=0. item_cnt=1 after 10 cycles and 29 after 290 cycles. At cycle 300: item_expire pulses for 1 cycle, flags=0, item_cnt=0.
- Arbitration: pickup_req=4'b0111 → only item_faster=1, pickup_grant=4'b0100. pickup_req=4'b0011 → item_frozen.
- Replace: with item_invincible active and item_cnt=12, pickup_req=4'b0010 → item_invincible=0, item_frozen=1, item_cnt=0. Expiry occurs 300 cycles after the replacement.
- Collision: pickup_req=4'b0001 asserted on the expiring tick cycle → item_expire stays 0, item_invincible=1, item_cnt=0.
- Pause: game_pause=1 for 50 cycles at item_cnt=5 → item_cnt stays 5 and the flag stays high. After release, the remaining schedule is shifted by exactly 50 cycles.
- Enable/reset: enable_reward=0 mid-item → all outputs 0 next cycle and pickups are ignored while low. rst_n=0 mid-item → outputs 0 asynchronously, with no expire pulse.
